// File: rtl/nco_lut_gen_if.sv
// Host/DAC-side bundle for the NCO: control, table write port and sample outputs.
interface nco_lut_gen_if #(
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int STEP_W = 16,
  parameter int RATE_W = 8
);
  // control
  logic                  en;
  logic                  preload;
  logic [ACC_W-1:0]      pl_phase;
  logic                  up_dn;
  logic [STEP_W-1:0]     step;
  logic [1:0]            mode;
  logic                  start;
  logic [RATE_W-1:0]     sweep_rate;
  // table write port
  logic                  tbl_we;
  logic [DATA_W/8-1:0]   tbl_wmask;
  logic [ADDR_W-1:0]     tbl_addr;
  logic [DATA_W-1:0]     tbl_wdata_sin;
  logic [DATA_W-1:0]     tbl_wdata_cos;
  // outputs
  logic [ACC_W-1:0]      phase;
  logic [DATA_W-1:0]     sine_out;
  logic [DATA_W-1:0]     cosine_out;
  logic                  out_valid;
  logic                  wrap;
  logic                  busy;
  logic                  done;

  modport master (
    output en, preload, pl_phase, up_dn, step, mode, start, sweep_rate,
           tbl_we, tbl_wmask, tbl_addr, tbl_wdata_sin, tbl_wdata_cos,
    input  phase, sine_out, cosine_out, out_valid, wrap, busy, done
  );

  modport slave (
    input  en, preload, pl_phase, up_dn, step, mode, start, sweep_rate,
           tbl_we, tbl_wmask, tbl_addr, tbl_wdata_sin, tbl_wdata_cos,
    output phase, sine_out, cosine_out, out_valid, wrap, busy, done
  );
endinterface

// File: rtl/nco_lut_gen.sv
// Phase-accumulator NCO with dual sine/cosine lookup tables.
// Modes: FREE, ONESHOT (one wrap then stop), SWEEP (saturating chirp), HOLD.
// Samples come out two cycles after the phase that addressed them.
module nco_lut_gen #(
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int STEP_W = 16,
  parameter int RATE_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  nco_lut_gen_if.slave bus
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NB     = DATA_W / 8;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {M_FREE = 2'd0, M_ONESHOT = 2'd1, M_SWEEP = 2'd2, M_HOLD = 2'd3} mode_e;
  typedef enum logic {OS_IDLE = 1'b0, OS_RUN = 1'b1} os_e;

  mode_e mode;
  assign mode = mode_e'(bus.mode);

  logic [ACC_W-1:0]  phase_q, phase_d;
  logic [STEP_W-1:0] cur_step_q, cur_step_d;
  logic              wrap_q, wrap_d;
  logic              busy_q, done_q;
  os_e               os_q;

  logic              adv, start_ok, carry;
  logic [ACC_W-1:0]  eff_step;
  logic [ACC_W:0]    acc_ext;
  logic [STEP_W:0]   step_sum;
  logic [STEP_W-1:0] step_sat;
  logic [STAGES:0]   vld_pipe;

  // table storage and read path (tables are never reset)
  logic [DATA_W-1:0] sin_mem [DEPTH];
  logic [DATA_W-1:0] cos_mem [DEPTH];
  logic [DATA_W-1:0] rd_sin_q, rd_cos_q;
  logic [DATA_W-1:0] sine_q, cos_q;
  logic [ADDR_W-1:0] rd_addr;

  // HOLD never advances; ONESHOT advances only while a run is in flight
  assign adv = bus.en && ((mode == M_FREE) || (mode == M_SWEEP) ||
                          ((mode == M_ONESHOT) && busy_q));
  assign start_ok = (mode == M_ONESHOT) && bus.start && !busy_q;

  // SWEEP uses the running chirp step; every other mode uses the live input
  assign eff_step = (mode == M_SWEEP) ? ACC_W'(cur_step_q) : ACC_W'(bus.step);
  assign acc_ext  = bus.up_dn ? ({1'b0, phase_q} + {1'b0, eff_step})
                              : ({1'b0, phase_q} - {1'b0, eff_step});
  // extra MSB is carry when adding and borrow when subtracting
  assign carry    = acc_ext[ACC_W];

  // chirp step saturates at full scale instead of wrapping
  assign step_sum = {1'b0, cur_step_q} + (STEP_W+1)'(bus.sweep_rate);
  assign step_sat = step_sum[STEP_W] ? {STEP_W{1'b1}} : step_sum[STEP_W-1:0];

  // next accumulator state: preload > oneshot start > advance
  always_comb begin
    phase_d    = phase_q;
    cur_step_d = cur_step_q;
    wrap_d     = 1'b0;
    if (bus.preload) begin
      phase_d    = bus.pl_phase;
      cur_step_d = bus.step;
    end else if (start_ok) begin
      phase_d = bus.pl_phase;
    end else if (adv) begin
      phase_d = acc_ext[ACC_W-1:0];
      wrap_d  = carry;
      if (mode == M_SWEEP) cur_step_d = step_sat;
    end
  end

  // accumulator and chirp-step registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      cur_step_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      cur_step_q <= cur_step_d;
      wrap_q     <= wrap_d;
    end
  end

  // one-shot run control; done only on a wrapping advance, never on abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_q   <= OS_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (os_q)
        OS_IDLE: begin
          if (!bus.preload && start_ok) begin
            os_q   <= OS_RUN;
            busy_q <= 1'b1;
          end
        end
        OS_RUN: begin
          if (bus.preload || (mode != M_ONESHOT)) begin
            os_q   <= OS_IDLE;
            busy_q <= 1'b0;
          end else if (adv && carry) begin
            os_q   <= OS_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          os_q   <= OS_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_addr = phase_q[ACC_W-1 -: ADDR_W];

  // byte-masked table write plus read-first registered read
  always_ff @(posedge clk) begin
    if (bus.tbl_we) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.tbl_wmask[b]) begin
          sin_mem[bus.tbl_addr][b*8 +: 8] <= bus.tbl_wdata_sin[b*8 +: 8];
          cos_mem[bus.tbl_addr][b*8 +: 8] <= bus.tbl_wdata_cos[b*8 +: 8];
        end
      end
    end
    rd_sin_q <= sin_mem[rd_addr];
    rd_cos_q <= cos_mem[rd_addr];
  end

  assign vld_pipe[0] = adv;

  // output sample registers and valid pipeline, aligned to the read path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sine_q             <= '0;
      cos_q              <= '0;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      sine_q             <= rd_sin_q;
      cos_q              <= rd_cos_q;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end

  assign bus.phase      = phase_q;
  assign bus.sine_out   = sine_q;
  assign bus.cosine_out = cos_q;
  assign bus.out_valid  = vld_pipe[STAGES];
  assign bus.wrap       = wrap_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_nco_lut_gen.sv
// Bench for nco_lut_gen: directed scenarios then random traffic, all checked
// against a plain-arithmetic model; samples go through a timestamped scoreboard.
module tb_nco_lut_gen;
  localparam int ACC_W  = 16;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int STEP_W = 16;
  localparam int RATE_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MOD    = 1 << ACC_W;
  localparam int SMAX   = (1 << STEP_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nco_lut_gen_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                   .STEP_W(STEP_W), .RATE_W(RATE_W)) bus ();

  nco_lut_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                .STEP_W(STEP_W), .RATE_W(RATE_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [31:0] s;
    logic [31:0] c;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference state
  int          m_phase, m_cur;
  bit          m_busy, m_done, m_wrap;
  logic [31:0] m_sin [DEPTH];
  logic [31:0] m_cos [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // monitor: pops on out_valid, flags late/missing samples by timestamp
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL out_valid_missing: expected sample for cyc %0d, none at cyc %0d", q[0].cyc, cyc);
          q.delete(0);
        end
        if (bus.out_valid === 1'b1) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_valid_spurious: got 1 expected 0 at cyc %0d", cyc);
          end else begin
            e = q.pop_front();
            chk("valid_cyc", 64'(cyc), 64'(e.cyc));
            chk("sine_out", 64'(bus.sine_out), 64'(e.s));
            chk("cosine_out", 64'(bus.cosine_out), 64'(e.c));
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.en = 1'b0; bus.preload = 1'b0; bus.pl_phase = '0; bus.up_dn = 1'b1;
    bus.step = '0; bus.mode = 2'd3; bus.start = 1'b0; bus.sweep_rate = '0;
    bus.tbl_we = 1'b0; bus.tbl_wmask = '0; bus.tbl_addr = '0;
    bus.tbl_wdata_sin = '0; bus.tbl_wdata_cos = '0;
  endtask

  // compare present state, advance the model by the inputs now applied, step a cycle
  task automatic tick();
    int md, addr, eff, s, a;
    bit adv;
    chk("phase", 64'(bus.phase), 64'(m_phase));
    chk("wrap", 64'(bus.wrap), 64'(m_wrap));
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("done", 64'(bus.done), 64'(m_done));
    md   = int'(bus.mode);
    adv  = bus.en && (md == 0 || md == 2 || (md == 1 && m_busy));
    addr = m_phase / (1 << (ACC_W - ADDR_W));
    if (adv) q.push_back('{cyc + 2, m_sin[addr], m_cos[addr]});
    m_done = 0;
    m_wrap = 0;
    if (bus.preload) begin
      m_phase = int'(bus.pl_phase);
      m_cur   = int'(bus.step);
      m_busy  = 0;
    end else if (md == 1 && bus.start && !m_busy) begin
      m_phase = int'(bus.pl_phase);
      m_busy  = 1;
    end else if (adv) begin
      eff = (md == 2) ? m_cur : int'(bus.step);
      s   = bus.up_dn ? m_phase + eff : m_phase - eff;
      m_wrap  = (s < 0) || (s >= MOD);
      m_phase = (s + MOD) % MOD;
      if (md == 2) m_cur = (m_cur + int'(bus.sweep_rate) > SMAX) ? SMAX : m_cur + int'(bus.sweep_rate);
      if (md == 1 && m_wrap) begin
        m_busy = 0;
        m_done = 1;
      end
    end
    if (md != 1) m_busy = 0;
    if (bus.tbl_we) begin
      a = int'(bus.tbl_addr);
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (bus.tbl_wmask[b]) begin
          m_sin[a][b*8 +: 8] = bus.tbl_wdata_sin[b*8 +: 8];
          m_cos[a][b*8 +: 8] = bus.tbl_wdata_cos[b*8 +: 8];
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    m_phase = 0; m_cur = 0; m_busy = 0; m_done = 0; m_wrap = 0;
    repeat (2) @(negedge clk);
    // reset values
    chk("rst_sine", 64'(bus.sine_out), 64'h0);
    chk("rst_cos", 64'(bus.cosine_out), 64'h0);
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    reset = 1'b0;

    // 1: fill tables sin=addr, cos=~addr, then free-run up
    for (int a = 0; a < DEPTH; a++) begin
      bus.tbl_we = 1'b1; bus.tbl_wmask = '1; bus.tbl_addr = ADDR_W'(a);
      bus.tbl_wdata_sin = 32'(a); bus.tbl_wdata_cos = ~32'(a);
      tick();
    end
    idle_inputs();
    bus.mode = 2'd0; bus.preload = 1'b1; bus.pl_phase = '0; bus.step = 16'h0080;
    tick();
    bus.preload = 1'b0; bus.en = 1'b1;
    repeat (20) tick();

    // 2: wrap up from FFC0, then borrow down from 0040
    bus.preload = 1'b1; bus.pl_phase = 16'hFFC0; bus.en = 1'b0;
    tick();
    bus.preload = 1'b0; bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    tick();
    chk("wrap_once", 64'(bus.wrap), 64'h0);
    bus.preload = 1'b1; bus.pl_phase = 16'h0040; bus.up_dn = 1'b0;
    tick();
    bus.preload = 1'b0; bus.en = 1'b1;
    tick();
    bus.en = 1'b0; bus.up_dn = 1'b1;
    tick();

    // 3: one-shot from F000 by 1000; repeated start while busy is ignored
    bus.mode = 2'd1; bus.pl_phase = 16'hF000; bus.step = 16'h1000; bus.start = 1'b1;
    tick();
    bus.pl_phase = 16'h1234;
    tick();
    bus.start = 1'b0; bus.en = 1'b1;
    repeat (5) tick();

    // 4: saturating sweep
    bus.mode = 2'd2; bus.preload = 1'b1; bus.pl_phase = '0; bus.step = 16'hFFF0;
    bus.sweep_rate = 8'h08; bus.en = 1'b0;
    tick();
    bus.preload = 1'b0; bus.en = 1'b1;
    repeat (5) tick();

    // 5: read-first collision at address 5
    bus.mode = 2'd3; bus.en = 1'b0;
    bus.tbl_we = 1'b1; bus.tbl_wmask = '1; bus.tbl_addr = 9'd5;
    bus.tbl_wdata_sin = 32'h11223344; bus.tbl_wdata_cos = 32'h55667788;
    tick();
    bus.tbl_we = 1'b0; bus.mode = 2'd0; bus.preload = 1'b1;
    bus.pl_phase = 16'(5 << (ACC_W - ADDR_W)); bus.step = '0;
    tick();
    bus.preload = 1'b0; bus.en = 1'b1;
    bus.tbl_we = 1'b1; bus.tbl_wmask = 4'b0010;
    bus.tbl_wdata_sin = 32'hAABBCCDD; bus.tbl_wdata_cos = 32'hAABBCCDD;
    tick();
    bus.tbl_we = 1'b0;
    repeat (3) tick();

    // 6: async reset in the middle of a long one-shot run
    bus.mode = 2'd1; bus.en = 1'b0; bus.pl_phase = '0; bus.step = 16'h0010; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.en = 1'b1;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_phase", 64'(bus.phase), 64'h0);
    chk("arst_sine", 64'(bus.sine_out), 64'h0);
    chk("arst_cos", 64'(bus.cosine_out), 64'h0);
    chk("arst_valid", 64'(bus.out_valid), 64'h0);
    chk("arst_busy", 64'(bus.busy), 64'h0);
    chk("arst_done", 64'(bus.done), 64'h0);
    chk("arst_wrap", 64'(bus.wrap), 64'h0);
    q.delete();
    m_phase = 0; m_cur = 0; m_busy = 0; m_done = 0; m_wrap = 0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    tick();
    // table retention: read back around a known region
    bus.mode = 2'd0; bus.preload = 1'b1; bus.pl_phase = 16'h0100; bus.step = 16'h0080;
    tick();
    bus.preload = 1'b0; bus.en = 1'b1;
    repeat (10) tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
      bus.en         = ($urandom_range(0, 9) != 0);
      bus.preload    = ($urandom_range(0, 19) == 0);
      bus.pl_phase   = ACC_W'($urandom);
      bus.up_dn      = 1'($urandom);
      bus.step       = ($urandom_range(0, 3) == 0) ? STEP_W'($urandom_range(0, 255)) : STEP_W'($urandom);
      bus.start      = ($urandom_range(0, 3) == 0);
      bus.sweep_rate = RATE_W'($urandom);
      bus.tbl_we     = ($urandom_range(0, 3) == 0);
      bus.tbl_wmask  = 4'($urandom);
      bus.tbl_addr   = ADDR_W'($urandom);
      bus.tbl_wdata_sin = $urandom;
      bus.tbl_wdata_cos = $urandom;
      tick();
    end

    idle_inputs();
    repeat (4) tick();
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nco_lut_gen.md
Name: nco_lut_gen

Overview:
Parametrised phase-accumulator numerically controlled oscillator with an internal dual sine/cosine lookup table. A wide phase accumulator advances by a programmable step, either up or down. Its top ADDR_W bits address two table RAMs, and each table has a host write port. The block adds three operating modes over a plain address counter: free-run, one-shot, and linear frequency sweep (chirp). It also provides output-valid, wrap, busy and done status, and sits between the host configuration bus and the DAC datapath.

Parameters:
ACC_W, 16, phase accumulator width (ACC_W >= ADDR_W)
ADDR_W, 9, table address width; depth = 2**ADDR_W
DATA_W, 32, table word width (multiple of 8)
STEP_W, 16, phase step width (STEP_W <= ACC_W)
RATE_W, 8, sweep increment width

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
en  in  1  advance enable; accumulator steps only when high
preload  in  1  load accumulator with pl_phase; load sweep step with step
pl_phase  in  ACC_W  preload phase value
up_dn  in  1  1 = add step, 0 = subtract step
step  in  STEP_W  phase increment, zero-extended to ACC_W
mode  in  2  0 = FREE, 1 = ONESHOT, 2 = SWEEP, 3 = HOLD
start  in  1  ONESHOT trigger
sweep_rate  in  RATE_W  per-advance step increment in SWEEP
tbl_we  in  1  table write strobe
tbl_wmask  in  DATA_W/8  byte write mask
tbl_addr  in  ADDR_W  table write address
tbl_wdata_sin  in  DATA_W  sine table write data
tbl_wdata_cos  in  DATA_W  cosine table write data
phase  out  ACC_W  current accumulator value
sine_out  out  DATA_W  registered sine sample
cosine_out  out  DATA_W  registered cosine sample
out_valid  out  1  sine_out/cosine_out correspond to an advanced phase
wrap  out  1  one-cycle pulse on accumulator carry (up) or borrow (down)
busy  out  1  ONESHOT sweep in progress
done  out  1  one-cycle pulse at ONESHOT completion

Behaviour:
- Reset (async): phase=0, cur_step=0, sine_out=0, cosine_out=0, out_valid=0, wrap=0, busy=0, done=0. The table contents are not reset.
- Accumulator priority per clk edge is reset > preload > advance.
- Preload sets phase=pl_phase and cur_step=step. It also clears busy without pulsing done, and produces no wrap.
- Advance condition: en and (mode==FREE, or mode==SWEEP, or (mode==ONESHOT and busy)). HOLD never advances.
- Effective step: cur_step in SWEEP, step in all other modes.
- Advance arithmetic: phase <= phase ± effective step, modulo 2**ACC_W.
- wrap=1 in the cycle after an advance that carried (up) or borrowed (down); otherwise wrap=0.
- SWEEP: on each advance, cur_step <= min(cur_step + sweep_rate, 2**STEP_W-1), saturating with no wrap.
- ONESHOT start: start while mode==ONESHOT and !busy loads phase=pl_phase and sets busy=1. Start while busy is ignored, as is start in any other mode. Preload has priority over start.
- ONESHOT completion: the advance that wraps clears busy, pulses done for one cycle and holds phase at the wrapped value.
- Leaving ONESHOT mode while busy clears busy with no done pulse.
- Table address = phase[ACC_W-1 -: ADDR_W].
- Read latency: the RAM read is registered at edge N+1 from phase at edge N, and the output register is loaded at edge N+2. sine_out/cosine_out therefore reflect the phase value present 2 cycles earlier.
- out_valid is the advance condition delayed by 2 cycles. Outputs update every cycle regardless of out_valid.
- Table write: on tbl_we, both tables write byte i of tbl_wdata_* where tbl_wmask[i]=1. The write port is independent of the accumulator.
- Write/read collision at the same address in the same cycle is read-first: the old word is returned.
- step=0 with advance: phase is unchanged and wrap never fires. A ONESHOT run with step=0 stays busy until mode change or preload.
- Reset mid-ONESHOT: busy=0, no done.

Test Plan:
1. Fill the sine table with word = addr and the cosine table with word = ~addr (wmask=all-ones), mode=FREE, preload 0, step=0x0080, up. Required response: sine_out sequence 0,1,2,… starting 2 cycles after the first advance; out_valid=1 aligned to it; cosine_out = ~sine_out.
2. FREE, up, preload 0xFFC0, step=0x0080. Required response: next phase=0x0040 and wrap=1 for exactly one cycle. Repeat with down from 0x0040: phase=0xFFC0 and wrap=1.
3. ONESHOT, pl_phase=0xF000, step=0x1000, start. Required response: busy=1; phase steps F000 → 0000 after 1 advance; done=1 for one cycle; busy=0; phase holds 0000 while en stays high; a second start while busy is ignored.
4. SWEEP, preload 0 with step=0xFFF0, sweep_rate=0x08. Required response: phase advances by FFF0, then FFF8, then FFFF, FFFF (saturated).
5. Write addr 5 with wmask=4'b0010, wdata=0xAABBCCDD over an old value of 0x11223344, while phase addresses 5. Required response: the read 2 cycles later shows 0x11223344 (read-first); the next read shows 0x1122CC44.
6. Assert reset asynchronously mid-ONESHOT between clock edges. Required response: all outputs are 0 immediately, no done pulse, and table contents are retained.
